ifetch_line_buffer: RTL and testbench
=====================================

// Module: ifetch_line_buffer
// PURPOSE
//   Responder side of the instruction-fetch handshake driven by the instruction register (ir).
//   Accepts instr_read/instr_mem_address requests and returns one 32-bit instruction with a
//   single-cycle instr_mem_resp pulse. Holds one cache line, refilled by burst from physical memory.
//   Sits between ir and the pmem arbiter. Redirects (load_pc/mispredict) kill in-flight fetches.
// PARAMETERS
//   BEAT_W      64  width of one pmem burst beat (bits)
//   LINE_BEATS  4   beats per line; line size = BEAT_W*LINE_BEATS/8 = 32 bytes
//   ADDR_W      32  address width
// PORTS
//   clk               in   1        clock, all state changes on posedge
//   rst               in   1        synchronous active-high reset
//   instr_read        in   1        ir fetch request; held high until instr_mem_resp
//   instr_mem_address in   ADDR_W   fetch byte address; [1:0] ignored
//   instr_mem_resp    out  1        one-cycle response pulse
//   in                out  32       instruction word; valid only while instr_mem_resp=1
//   flush             in   1        redirect: abandon the current request
//   pmem_read         out  1        burst read request; held until last beat
//   pmem_address      out  ADDR_W   line-aligned address (low 5 bits zero)
//   pmem_resp         in   1        one beat valid this cycle
//   pmem_rdata        in   BEAT_W   beat data, beat 0 = lowest address
// BEHAVIOUR
//   Reset: state=IDLE, line_valid=0, beat_cnt=0, instr_mem_resp=0, in=0, pmem_read=0, pmem_address=0.
//   Line state: tag=addr[31:5], line_valid, data[255:0]. Word select = addr[4:2].
//   Hit: line_valid && tag==addr[31:5].
//   FSM:
//     IDLE: instr_read && !flush && hit  -> RESP (latch word).
//           instr_read && !flush && !hit -> FILL (pmem_read=1, pmem_address={addr[31:5],5'b0},
//           line_valid=0, latch request address, beat_cnt=0).
//     FILL: each pmem_resp writes pmem_rdata to beat beat_cnt, then beat_cnt++.
//           On the beat with beat_cnt==LINE_BEATS-1: pmem_read drops next cycle, line_valid=1,
//           tag updated, then -> RESP (or -> IDLE if killed).
//     RESP: instr_mem_resp=1, in=selected word, for exactly one cycle -> IDLE.
//   Latency: a hit responds the cycle after the request is sampled. A miss responds the cycle after the last beat.
//   instr_read is not sampled in RESP. The next request is accepted in IDLE the following cycle
//     (peak rate: 1 instruction per 2 cycles).
//   Address is captured at acceptance. Address changes while in FILL/RESP are ignored.
//   flush:
//     in IDLE, the request is dropped.
//     in FILL, a kill flag is set. The burst cannot be cancelled: it completes, the line becomes valid,
//       no response is issued, and the FSM returns to IDLE.
//     in RESP, instr_mem_resp is forced 0 and the FSM goes to IDLE.
//     flush on the same cycle as the last beat: the line is installed and no response is issued.
//   pmem_resp outside FILL is ignored.
//   Reset mid-fill: immediate return to reset state. The pmem side is reset by the same rst,
//     so no orphan beats arrive.
//   Beat counter wraps only via FSM exit and is never incremented past LINE_BEATS-1.
// CONFIGURATION
//   IFETCH_PERF_CNT_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
//     Both are cleared by rst and incremented on each accepted (non-flushed) hit/miss.
//     Both wrap at 2^32.
//   IFETCH_PERF_CNT_EN undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
//   1 Reset 5 cycles -> instr_mem_resp=0, pmem_read=0, line_valid=0 on the first cycle after rst drops.
//   2 Cold miss: read 0x60. Expect pmem_read=1 and pmem_address=0x60 next cycle.
//     Beats 0x0001f133_000170b3, 0x00c10113_00b08093, ... are returned.
//     Expect a single resp with in=0x000170b3 the cycle after beat 3.
//   3 Hit after 2: read 0x64 -> resp next cycle with in=0x0001f133, pmem_read stays 0.
//     Read 0x6C -> in=0x00c10113.
//   4 Replace: read 0x80 -> miss, fill with pmem_address=0x80. Then read 0x60 -> miss again.
//   5 flush during fill of 0xA0 (after beat 1) -> burst completes, no resp.
//     Then read 0xA4 -> hit, 1-cycle resp. Flush in RESP cycle -> resp stays 0.
//   6 IFETCH_PERF_CNT_EN: run scenarios 2-4 -> hit_count=2, miss_count=3. rst mid-fill -> both 0, pmem_read=0.

Source files
------------

// File: rtl/ifetch_line_buffer.sv
// ifetch_line_buffer: single-line instruction buffer between the ir fetch
// port and the pmem arbiter. A hit answers the cycle after the request is
// accepted. A miss refills the whole line with a pmem burst, then answers.
// A flush (redirect) abandons the request. A burst that has started always
// completes and installs the line.
//
// Optional build macro: IFETCH_PERF_CNT_EN adds the hit_count and
// miss_count outputs.
//
// ir handshake: instr_read is held high until instr_mem_resp. The address is
// captured when the request is accepted. instr_mem_resp is a one-cycle pulse.
// instr_read is not sampled in the response cycle.
// pmem handshake: pmem_read is held high for the whole burst. Each cycle
// with pmem_resp high delivers one beat, lowest address first. pmem_resp is
// ignored while no burst is active.
module ifetch_line_buffer #(
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_mem_address,
    output logic              instr_mem_resp,
    output logic [31:0]       in,
    input  logic              flush,
    output logic              pmem_read,
    output logic [ADDR_W-1:0] pmem_address,
    input  logic              pmem_resp,
    input  logic [BEAT_W-1:0] pmem_rdata,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [1:0]        dbg_state,
    output logic              dbg_line_valid
);

    localparam int LINE_W = BEAT_W * LINE_BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int BCNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    logic                line_valid;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   data_q;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   req_wsel;
    logic                kill;
    logic                resp_q;
    logic [31:0]         in_q;

    logic                hit;
    logic                accept;
    logic                beat_fire;
    logic                last_beat;
    logic [LINE_W-1:0]   line_next;
    logic [31:0]         hit_word;
    logic [31:0]         fill_word;
    logic [TAG_W-1:0]    addr_tag;
    logic [WSEL_W-1:0]   addr_wsel;
    logic                unused_addr_bits;

    assign addr_tag         = instr_mem_address[ADDR_W-1:OFF_W];
    assign addr_wsel        = instr_mem_address[OFF_W-1:2];
    assign unused_addr_bits = ^instr_mem_address[1:0];

    assign hit       = line_valid && (tag_q == addr_tag);
    assign accept    = (state == S_IDLE) && instr_read && !flush;
    assign beat_fire = (state == S_FILL) && pmem_resp;
    assign last_beat = beat_fire && (beat_cnt == BCNT_W'(LINE_BEATS - 1));

    // Line contents including the beat arriving this cycle, so the requested
    // word can be latched on the very edge that completes the burst.
    always_comb begin
        line_next = data_q;
        if (beat_fire) begin
            line_next[int'(beat_cnt) * BEAT_W +: BEAT_W] = pmem_rdata;
        end
    end

    // Word selection for the hit path (live address) and the fill path
    // (address captured at acceptance).
    always_comb begin
        hit_word  = data_q[int'(addr_wsel) * 32 +: 32];
        fill_word = line_next[int'(req_wsel) * 32 +: 32];
    end

    // Main FSM: accept, refill, respond. All outputs except the flush gate
    // on the response are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            line_valid   <= 1'b0;
            tag_q        <= '0;
            data_q       <= '0;
            beat_cnt     <= '0;
            req_tag      <= '0;
            req_wsel     <= '0;
            kill         <= 1'b0;
            resp_q       <= 1'b0;
            in_q         <= '0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            in_q   <= hit_word;
                            resp_q <= 1'b1;
                            state  <= S_RESP;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {addr_tag, {OFF_W{1'b0}}};
                            line_valid   <= 1'b0;
                            req_tag      <= addr_tag;
                            req_wsel     <= addr_wsel;
                            beat_cnt     <= '0;
                            kill         <= 1'b0;
                            state        <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (beat_fire) begin
                        data_q <= line_next;
                        if (last_beat) begin
                            beat_cnt   <= '0;
                            pmem_read  <= 1'b0;
                            line_valid <= 1'b1;
                            tag_q      <= req_tag;
                            if (kill || flush) begin
                                state <= S_IDLE;
                            end else begin
                                in_q   <= fill_word;
                                resp_q <= 1'b1;
                                state  <= S_RESP;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    resp_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    resp_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // A redirect arriving in the response cycle suppresses the pulse.
    assign instr_mem_resp = resp_q && !flush;
    assign in             = in_q;
    assign dbg_state      = state;
    assign dbg_line_valid = line_valid;

`ifdef IFETCH_PERF_CNT_EN
    // Count accepted hits and misses. Flushed requests are never accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Bench for ifetch_line_buffer. It pairs a behavioural pmem responder with a
// line/tag reference model, and a response scoreboard with expected queues.
module tb_ifetch_line_buffer;

    localparam int BEAT_W     = 64;
    localparam int LINE_BEATS = 4;
    localparam int ADDR_W     = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_read = 1'b0;
    logic [ADDR_W-1:0] instr_mem_address = '0;
    logic              instr_mem_resp;
    logic [31:0]       in_w;
    logic              flush = 1'b0;
    logic              pmem_read;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_resp = 1'b0;
    logic [BEAT_W-1:0] pmem_rdata = '0;
    logic [1:0]        dbg_state;
    logic              dbg_line_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    always #5 clk = ~clk;

    ifetch_line_buffer #(
        .BEAT_W(BEAT_W), .LINE_BEATS(LINE_BEATS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_read(instr_read),
        .instr_mem_address(instr_mem_address),
        .instr_mem_resp(instr_mem_resp),
        .in(in_w),
        .flush(flush),
        .pmem_read(pmem_read),
        .pmem_address(pmem_address),
        .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata),
`ifdef IFETCH_PERF_CNT_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .dbg_state(dbg_state),
        .dbg_line_valid(dbg_line_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_fill_q[$];

    // Reference model: the single buffered line plus the expected counters.
    bit          m_valid = 0;
    logic [31:0] m_line  = '0;
    int          m_hits  = 0;
    int          m_misses = 0;

    // Backing memory: preset words plus a hash-generated default.
    logic [31:0] mem_words [int];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (mem_words.exists(k)) return mem_words[k];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, required event never seen", name);
    endtask

    // Scoreboard monitor: every response pulse is matched against the queue.
    always @(negedge clk) begin
        if (instr_mem_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: in=0x%08h, no response expected", in_w);
            end else begin
                check("resp_word", in_w, exp_q.pop_front());
            end
        end
    end

    // pmem responder: checks each burst address, returns beats with random
    // gaps, and sprays ignored garbage beats while no burst is active.
    int          beats_done = 0;
    int          cur_beat   = -1;
    bit          real_beat  = 0;
    bit          burst_on   = 0;
    logic [31:0] burst_line = '0;

    always @(posedge clk) begin
        #1;
        if (pmem_resp && real_beat) beats_done++;
        pmem_resp = 1'b0;
        real_beat = 0;
        cur_beat  = -1;
        if (rst || !pmem_read) begin
            beats_done = 0;
            burst_on   = 0;
            if (!rst && $urandom_range(0, 7) == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = {$urandom, $urandom};
            end
        end else begin
            if (!burst_on) begin
                burst_on = 1;
                if (exp_fill_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fill: pmem_address=0x%08h, no fill expected", pmem_address);
                    burst_line = pmem_address;
                end else begin
                    burst_line = exp_fill_q.pop_front();
                    check("fill_address", pmem_address, burst_line);
                end
            end
            if (beats_done < LINE_BEATS && $urandom_range(0, 3) != 0) begin
                pmem_resp  = 1'b1;
                real_beat  = 1;
                cur_beat   = beats_done;
                pmem_rdata = {mem_word(burst_line + 32'(8 * beats_done + 4)),
                              mem_word(burst_line + 32'(8 * beats_done))};
            end
        end
    end

    // One fetch. mode: 0 plain, 1 flush at request, 2 flush in the cycle of
    // beat fbeat (miss only), 3 flush in the response cycle (hit only).
    task automatic do_fetch(input logic [31:0] addr, input int mode_in, input int fbeat);
        bit          is_hit;
        bit          got;
        bit          fl_done;
        bit          done;
        int          cyc;
        int          last_cyc;
        int          mode;
        logic [31:0] line;
        mode   = mode_in;
        line   = addr & ~32'h1F;
        is_hit = m_valid && (m_line == line);
        if (mode == 1) begin
            instr_read = 1'b1;
            instr_mem_address = addr;
            flush = 1'b1;
            @(negedge clk);
            instr_read = 1'b0;
            flush = 1'b0;
            repeat (2) @(negedge clk);
            return;
        end
        if (mode == 2 && is_hit) mode = 0;
        if (mode == 3 && !is_hit) mode = 0;
        if (is_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            exp_fill_q.push_back(line);
            m_valid = 1;
            m_line  = line;
        end
        if (mode == 0) exp_q.push_back(mem_word(addr & ~32'h3));
        instr_read = 1'b1;
        instr_mem_address = addr;
        if (mode == 3) begin
            @(posedge clk);
            #1;
            flush = 1'b1;
            instr_read = 1'b0;
            @(negedge clk);
            check("resp_forced_low", instr_mem_resp, 0);
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(negedge clk);
            return;
        end
        got = 0; fl_done = 0; done = 0; cyc = 0; last_cyc = -10;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (flush) flush = 1'b0;
            if (mode == 0 && instr_mem_resp === 1'b1) begin
                got = 1;
                done = 1;
            end else if (mode == 2 && fl_done && !pmem_read) begin
                done = 1;
            end else begin
                if (pmem_resp && cur_beat == LINE_BEATS - 1) last_cyc = cyc;
                if (mode == 2 && !fl_done && pmem_resp && cur_beat == fbeat) begin
                    flush = 1'b1;
                    instr_read = 1'b0;
                    fl_done = 1;
                end else if (!is_hit) begin
                    instr_mem_address = $urandom;
                end
            end
        end
        instr_read = 1'b0;
        if (!done) begin
            note_fail(mode == 0 ? "resp_timeout" : "flush_fill_timeout");
        end else if (mode == 0) begin
            if (is_hit) check("hit_latency", 64'(cyc), 64'd1);
            else        check("miss_latency", 64'(cyc), 64'(last_cyc + 1));
        end
        repeat (2) @(negedge clk);
    endtask

    // Reset while a fill is in flight, then confirm the reset state.
    task automatic do_reset_midfill(input logic [31:0] addr);
        int cyc;
        cyc = 0;
        exp_fill_q.push_back(addr & ~32'h1F);
        instr_read = 1'b1;
        instr_mem_address = addr;
        while (!(pmem_resp && cur_beat == 1) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) note_fail("midfill_beat_timeout");
        rst = 1'b1;
        instr_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_valid = 0; m_hits = 0; m_misses = 0;
        @(negedge clk);
        check("rst_mid_pmem_read", pmem_read, 0);
        check("rst_mid_resp", instr_mem_resp, 0);
        check("rst_mid_line_valid", dbg_line_valid, 0);
        check("rst_mid_state", dbg_state, 0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_mid_hit_count", hit_count, 0);
        check("rst_mid_miss_count", miss_count, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        mem_words[32'h60 >> 2] = 32'h000170b3;
        mem_words[32'h64 >> 2] = 32'h0001f133;
        mem_words[32'h68 >> 2] = 32'h00b08093;
        mem_words[32'h6C >> 2] = 32'h00c10113;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_resp", instr_mem_resp, 0);
        check("reset_pmem_read", pmem_read, 0);
        check("reset_line_valid", dbg_line_valid, 0);
        check("reset_state", dbg_state, 0);
        check("reset_pmem_address", pmem_address, 0);
        check("reset_in", in_w, 0);

        // Cold miss, hits, replacement.
        do_fetch(32'h60, 0, 0);
        do_fetch(32'h64, 0, 0);
        do_fetch(32'h6C, 0, 0);
        do_fetch(32'h80, 0, 0);
        do_fetch(32'h60, 0, 0);
`ifdef IFETCH_PERF_CNT_EN
        check("hit_count_s234", hit_count, 2);
        check("miss_count_s234", miss_count, 3);
`endif

        // Redirect cases.
        do_fetch(32'hA0, 2, 1);
        do_fetch(32'hA4, 0, 0);
        do_fetch(32'hA8, 3, 0);
        do_fetch(32'hAC, 0, 0);
        do_fetch(32'hC0, 2, 3);
        do_fetch(32'hC4, 0, 0);
        do_fetch(32'hE0, 1, 0);
        do_fetch(32'hE0, 0, 0);
        do_fetch(32'hE4, 2, 0);

        // Random traffic with locality and mixed redirects.
        for (int i = 0; i < 200; i++) begin
            if (m_valid && $urandom_range(0, 9) < 6)
                a = m_line + 32'(4 * $urandom_range(0, 7));
            else
                a = 32'($urandom_range(0, 15)) << 5 | 32'(4 * $urandom_range(0, 7));
            a = a | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      do_fetch(a, 1, 0);
            else if (r == 1) do_fetch(a, 2, $urandom_range(0, 3));
            else if (r == 2) do_fetch(a, 3, 0);
            else             do_fetch(a, 0, 0);
        end
`ifdef IFETCH_PERF_CNT_EN
        check("hit_count_random", hit_count, 64'(m_hits));
        check("miss_count_random", miss_count, 64'(m_misses));
`endif

        do_reset_midfill(m_valid ? (m_line + 32'h100) : 32'h100);
        do_fetch(32'h64, 0, 0);
        do_fetch(32'h68, 0, 0);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 0);
        check("fill_q_drained", 64'(exp_fill_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
